if_id_branch_ctrl: RTL and testbench
====================================

Name: if_id_branch_ctrl

Overview:
- Consumer end of the fetch interface. Captures the fetch stage's next-PC value (PC+4) and instruction into the IF/ID pipeline register.
- Drives the fetch stage's three control inputs: freeze, branch-taken and branch address. It does this by detecting hazards and resolving BEQ/BNE/J in the decode stage.
- Sits between the fetch stage and the decode/register-file logic. Also feeds a bubble request to the ID/EX register.

Parameters:
- WIDTH, 32, data/address width
- CNT_W, 16, width of the saturating stall and flush counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc_in  in  WIDTH  next-PC value (PC+4) from the fetch stage
- inst_in  in  WIDTH  instruction from the fetch stage
- rs_data  in  WIDTH  register-file read of if_id_inst[25:21]
- rt_data  in  WIDTH  register-file read of if_id_inst[20:16]
- ex_mem_read  in  1  instruction in EX is LW
- ex_wb_en  in  1  instruction in EX writes a register
- ex_dest  in  5  destination register of the EX instruction
- mem_mem_read  in  1  instruction in MEM is LW
- mem_dest  in  5  destination register of the MEM instruction
- if_id_pc  out  WIDTH  registered PC+4
- if_id_inst  out  WIDTH  registered instruction
- freeze  out  1  stall request to the fetch stage's freeze input
- id_bubble  out  1  forces a NOP into ID/EX; equals freeze
- branch_taken  out  1  redirect request to the fetch stage
- branch_addr  out  WIDTH  redirect target
- stall_cnt  out  CNT_W  saturating count of freeze cycles
- flush_cnt  out  CNT_W  saturating count of taken redirects

Behaviour:
- Reset (async, immediate): if_id_pc=0, if_id_inst=0 (NOP), stall_cnt=0, flush_cnt=0. The combinational outputs then evaluate against a NOP, so freeze=0 and branch_taken=0. Reset mid-stall or mid-branch discards the held instruction.
- Decode fields from if_id_inst: op=[31:26], rs=[25:21], rt=[20:16], imm=[15:0], tgt=[25:0].
- Opcodes: BEQ=6'h04, BNE=6'h05, J=6'h02, LW=6'h23.
- uses_rt is true for R-type (op=0), BEQ and BNE. Register 0 never causes a hazard.
- Load-use hazard: ex_mem_read, ex_dest!=0, and ex_dest==rs, or (uses_rt and ex_dest==rt).
- Branch hazard (BEQ/BNE only; no forwarding into ID), either of:
  - ex_wb_en with ex_dest matching rs/rt (nonzero);
  - mem_mem_read with mem_dest matching rs/rt (nonzero).
- freeze = load-use hazard OR branch hazard. Purely combinational from the IF/ID register and the hazard inputs; same cycle.
- Branch resolution, combinational:
  - BEQ is taken when rs_data==rt_data; BNE when they differ; J is always taken.
  - branch_taken = taken AND NOT freeze. Freeze dominates; the branch re-evaluates once the stall clears.
- branch_addr:
  - BEQ/BNE: if_id_pc + (sign-extend(imm) << 2), mod 2^WIDTH (wraps, no error).
  - J: {if_id_pc[31:28], tgt, 2'b00}.
  - Otherwise 0.
- IF/ID register update at the rising edge, in priority order:
  - branch_taken=1: flush. if_id_inst<=0 and if_id_pc<=0, discarding the wrong-path fetch.
  - else freeze=1: hold both registers.
  - else: load pc_in and inst_in.
- branch_taken and freeze are never both 1 (by construction; an assertion checks this).
- Counters: stall_cnt +1 on each cycle freeze=1; flush_cnt +1 on each cycle branch_taken=1. Both saturate at all-ones with no wrap.
- Latency:
  - The fetched instruction is visible on if_id_inst 1 cycle after it is presented.
  - Redirect takes effect at the next edge, with a one-instruction penalty (the flushed slot).
- A load-use stall lasts 1 cycle. A branch dependent on an ALU op stalls 1 cycle; a branch dependent on a LW stalls 2 cycles (EX, then MEM).

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_LW), instruction field bit positions, NOP encoding.
- One sub-module, hazard_detect: purely combinational. Inputs are the decoded rs/rt/uses_rt/is_branch fields plus the EX/MEM hazard inputs; output is freeze.
- The register, branch resolution and counters stay in the top module.

Test Plan:
- Straight-line fetch: pc_in=4,8,12 with inst=ADD → if_id_pc follows one cycle later; freeze=0, branch_taken=0, counters stay 0.
- Load-use: if_id_inst=ADD $3,$1,$2 with ex_mem_read=1, ex_dest=1 → freeze=1 and id_bubble=1 for 1 cycle; IF/ID held; stall_cnt=1.
- BEQ taken: if_id_pc=0x100, imm=0x0003, rs_data=rt_data=5 → branch_taken=1, branch_addr=0x10C. Next cycle if_id_inst=0; flush_cnt=1.
- BNE with negative offset: if_id_pc=0x100, imm=0xFFFE, rs_data=1, rt_data=2 → branch_addr=0xF8, taken. With equal data → not taken and no flush.
- Branch after LW: BEQ $4,$5 with ex_mem_read=1 and ex_dest=4 for cycle 1, then mem_mem_read=1 and mem_dest=4 for cycle 2 → freeze for 2 cycles with branch_taken=0; resolves in cycle 3. J tgt=0x40 at if_id_pc=0x1000_0004 → branch_addr=0x1000_0100.
- Async reset asserted mid-freeze, between clock edges → outputs clear immediately: if_id_inst=0, freeze=0, counters=0. Also: force stall_cnt to all-ones and hold the hazard; the count stays at all-ones.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode constants for the IF/ID branch/hazard control slice.
// Contents: opcode values, instruction field bit positions, NOP encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  // All-zero word decodes as sll $0,$0,0: a true no-op.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the instruction held in IF/ID.
// Inputs : rs, rt, uses_rt, is_branch (decoded from IF/ID),
//          ex_mem_read, ex_wb_en, ex_dest (EX stage),
//          mem_mem_read, mem_dest (MEM stage).
// Output : freeze - stall fetch and insert a bubble into ID/EX.
module hazard_detect
  import mips_pkg::*;
(
  input  logic       is_branch,
  input  logic       uses_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_mem_read,
  input  logic       ex_wb_en,
  input  logic [4:0] ex_dest,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_dest,
  output logic       freeze
);

  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic branch_haz;

  // $0 is hard-wired, so a write to it never creates a dependency.
  assign ex_hit  = (ex_dest != 5'd0) &&
                   ((ex_dest == rs) || (uses_rt && (ex_dest == rt)));
  assign mem_hit = (mem_dest != 5'd0) &&
                   ((mem_dest == rs) || (uses_rt && (mem_dest == rt)));

  assign load_use = ex_mem_read && ex_hit;

  // Branches compare in ID with no forwarding path, so any pending ALU
  // result in EX or load in MEM must retire first.
  assign branch_haz = is_branch &&
                      ((ex_wb_en && ex_hit) || (mem_mem_read && mem_hit));

  assign freeze = load_use || branch_haz;

endmodule

// File: rtl/if_id_branch_ctrl.sv
// IF/ID pipeline register with decode-stage branch resolution and hazard
// stalling.
// Inputs : clk, rst (async, active-high), pc_in/inst_in from fetch,
//          rs_data/rt_data register-file reads, EX/MEM hazard info.
// Outputs: if_id_pc/if_id_inst register, freeze/id_bubble stall request,
//          branch_taken/branch_addr redirect, stall_cnt/flush_cnt
//          saturating event counters.
module if_id_branch_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] inst_in,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             ex_mem_read,
  input  logic             ex_wb_en,
  input  logic [4:0]       ex_dest,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  output logic [WIDTH-1:0] if_id_pc,
  output logic [WIDTH-1:0] if_id_inst,
  output logic             freeze,
  output logic             id_bubble,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_addr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [5:0]              op;
  logic [4:0]              rs;
  logic [4:0]              rt;
  logic [15:0]             imm;
  logic [25:0]             tgt;
  logic                    is_beq;
  logic                    is_bne;
  logic                    is_j;
  logic                    is_branch;
  logic                    uses_rt;
  logic                    taken_raw;
  logic signed [WIDTH-1:0] br_off;

  assign op  = if_id_inst[OP_HI:OP_LO];
  assign rs  = if_id_inst[RS_HI:RS_LO];
  assign rt  = if_id_inst[RT_HI:RT_LO];
  assign imm = if_id_inst[IMM_HI:IMM_LO];
  assign tgt = if_id_inst[TGT_HI:TGT_LO];

  assign is_beq    = (op == OP_BEQ);
  assign is_bne    = (op == OP_BNE);
  assign is_j      = (op == OP_J);
  assign is_branch = is_beq || is_bne;
  assign uses_rt   = (op == OP_RTYPE) || is_branch;

  hazard_detect u_hazard (
    .is_branch    (is_branch),
    .uses_rt      (uses_rt),
    .rs           (rs),
    .rt           (rt),
    .ex_mem_read  (ex_mem_read),
    .ex_wb_en     (ex_wb_en),
    .ex_dest      (ex_dest),
    .mem_mem_read (mem_mem_read),
    .mem_dest     (mem_dest),
    .freeze       (freeze)
  );

  assign id_bubble = freeze;

  // Word offset, sign-extended; the add below wraps modulo 2^WIDTH.
  assign br_off = {{(WIDTH-18){imm[15]}}, imm, 2'b00};

  assign taken_raw = (is_beq && (rs_data == rt_data)) ||
                     (is_bne && (rs_data != rt_data)) ||
                     is_j;

  // A stalled branch is reading stale operands; hold off and retry.
  assign branch_taken = taken_raw && !freeze;

  always_comb begin
    branch_addr = '0;
    if (is_branch)
      branch_addr = if_id_pc + $unsigned(br_off);
    else if (is_j)
      branch_addr = {if_id_pc[WIDTH-1:28], tgt, 2'b00};
  end

  // ---- IF -> ID stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc   <= '0;
      if_id_inst <= WIDTH'(NOP_INST);
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (branch_taken) begin
        if_id_pc   <= '0;
        if_id_inst <= WIDTH'(NOP_INST);
      end else if (!freeze) begin
        if_id_pc   <= pc_in;
        if_id_inst <= inst_in;
      end
      if (freeze)
        stall_cnt <= sat_inc(stall_cnt);
      if (branch_taken)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end

  a_taken_freeze_excl : assert property (
    @(posedge clk) disable iff (rst) !(branch_taken && freeze)
  );

endmodule

// File: tb/tb_if_id_branch_ctrl.sv
module tb_if_id_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_wb_en = 1'b0;
  logic [4:0]  ex_dest = '0;
  logic        mem_mem_read = 1'b0;
  logic [4:0]  mem_dest = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        freeze;
  logic        id_bubble;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  if_id_branch_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .inst_in      (inst_in),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .ex_mem_read  (ex_mem_read),
    .ex_wb_en     (ex_wb_en),
    .ex_dest      (ex_dest),
    .mem_mem_read (mem_mem_read),
    .mem_dest     (mem_dest),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
    .freeze       (freeze),
    .id_bubble    (id_bubble),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] low);
    return {op, rs, rt, low};
  endfunction

  function automatic logic dep(input logic [4:0] d, input logic [31:0] inst);
    logic [5:0] op;
    logic       ur;
    op = inst[31:26];
    ur = (op == 6'h00) || (op == 6'h04) || (op == 6'h05);
    if (d == 5'd0) return 1'b0;
    return (d == inst[25:21]) || (ur && (d == inst[20:16]));
  endfunction

  task automatic model_comb(input logic [31:0] pc, input logic [31:0] inst,
                            input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic exmr, input logic exwb, input logic [4:0] exd,
                            input logic memmr, input logic [4:0] memd,
                            output logic f, output logic t, output logic [31:0] a);
    logic [5:0] op;
    logic       br;
    logic       tk;
    op = inst[31:26];
    br = (op == 6'h04) || (op == 6'h05);
    f  = (exmr && dep(exd, inst)) ||
         (br && ((exwb && dep(exd, inst)) || (memmr && dep(memd, inst))));
    case (op)
      6'h04: begin tk = (rsd == rtd); a = pc + {{14{inst[15]}}, inst[15:0], 2'b00}; end
      6'h05: begin tk = (rsd != rtd); a = pc + {{14{inst[15]}}, inst[15:0], 2'b00}; end
      6'h02: begin tk = 1'b1;         a = {pc[31:28], inst[25:0], 2'b00}; end
      default: begin tk = 1'b0;       a = 32'h0; end
    endcase
    t = tk && !f;
  endtask

  // One clock cycle: drive at the falling edge, check the current state
  // against the scoreboard, then push the state expected after the next
  // rising edge.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] rsd = 0, input logic [31:0] rtd = 0,
                      input logic exmr = 0, input logic exwb = 0, input logic [4:0] exd = 0,
                      input logic memmr = 0, input logic [4:0] memd = 0);
    exp_t        e;
    exp_t        n;
    logic        f;
    logic        t;
    logic [31:0] a;
    @(negedge clk);
    pc_in = pc; inst_in = inst; rs_data = rsd; rt_data = rtd;
    ex_mem_read = exmr; ex_wb_en = exwb; ex_dest = exd;
    mem_mem_read = memmr; mem_dest = memd;
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, ".pc"},    if_id_pc,   e.pc);
    check({tag, ".inst"},  if_id_inst, e.inst);
    check({tag, ".stall"}, {16'h0, stall_cnt}, {16'h0, e.stall});
    check({tag, ".flush"}, {16'h0, flush_cnt}, {16'h0, e.flush});
    model_comb(e.pc, e.inst, rsd, rtd, exmr, exwb, exd, memmr, memd, f, t, a);
    check({tag, ".freeze"}, {31'h0, freeze},       {31'h0, f});
    check({tag, ".bubble"}, {31'h0, id_bubble},    {31'h0, f});
    check({tag, ".taken"},  {31'h0, branch_taken}, {31'h0, t});
    check({tag, ".addr"},   branch_addr, a);
    n = e;
    if (t) begin
      n.pc = 32'h0; n.inst = 32'h0;
    end else if (!f) begin
      n.pc = pc; n.inst = inst;
    end
    if (f && (n.stall != 16'hFFFF)) n.stall = n.stall + 16'd1;
    if (t && (n.flush != 16'hFFFF)) n.flush = n.flush + 16'd1;
    sb.push_back(n);
  endtask

  task automatic release_reset();
    exp_t z;
    @(negedge clk);
    pc_in = '0; inst_in = '0; rs_data = '0; rt_data = '0;
    ex_mem_read = 1'b0; ex_wb_en = 1'b0; ex_dest = '0;
    mem_mem_read = 1'b0; mem_dest = '0;
    rst = 1'b0;
    z.pc = '0; z.inst = '0; z.stall = '0; z.flush = '0;
    sb.delete();
    sb.push_back(z);
  endtask

  logic [31:0] add_321;
  logic [31:0] beq_12;
  logic [31:0] bne_12;
  logic [31:0] beq_45;
  logic [31:0] j_40;
  logic [31:0] add_300;

  initial begin
    add_321 = mk_i(6'h00, 5'd1, 5'd2, {5'd3, 5'd0, 6'h20});
    beq_12  = mk_i(6'h04, 5'd1, 5'd2, 16'h0003);
    bne_12  = mk_i(6'h05, 5'd1, 5'd2, 16'hFFFE);
    beq_45  = mk_i(6'h04, 5'd4, 5'd5, 16'h0003);
    j_40    = {6'h02, 26'h40};
    add_300 = mk_i(6'h00, 5'd0, 5'd0, {5'd3, 5'd0, 6'h20});

    #1;
    check("rst.pc",     if_id_pc,   32'h0);
    check("rst.inst",   if_id_inst, 32'h0);
    check("rst.freeze", {31'h0, freeze},       32'h0);
    check("rst.taken",  {31'h0, branch_taken}, 32'h0);
    check("rst.stall",  {16'h0, stall_cnt},    32'h0);
    repeat (2) @(posedge clk);
    release_reset();

    // straight-line fetch
    step("seq4",  32'd4,  add_321);
    step("seq8",  32'd8,  add_321);
    step("seq12", 32'd12, add_321);
    // load-use on rs=$1: one stall cycle, then release
    step("lu_stall", 32'd16, 32'h0, 0, 0, 1'b1, 1'b1, 5'd1);
    check("lu_freeze_lit", {31'h0, freeze}, 32'h1);
    step("lu_go",    32'd16, 32'h0);
    step("lu_after", 32'd20, 32'h0);
    check("lu_stall_lit", {16'h0, stall_cnt}, 32'h1);

    // BEQ taken
    step("beq_ld",  32'h100, beq_12);
    step("beq_tk",  32'h104, add_321, 32'd5, 32'd5);
    check("beq_addr_lit",  branch_addr, 32'h10C);
    check("beq_taken_lit", {31'h0, branch_taken}, 32'h1);
    step("beq_fl",  32'h10C, add_321);
    check("beq_inst_lit",  if_id_inst, 32'h0);
    check("beq_flush_lit", {16'h0, flush_cnt}, 32'h1);

    // BNE negative offset, taken then not taken
    step("bne_ld",  32'h100, bne_12);
    step("bne_tk",  32'h104, add_321, 32'd1, 32'd2);
    check("bne_addr_lit", branch_addr, 32'hF8);
    step("bne_ld2", 32'h100, bne_12);
    step("bne_nt",  32'h104, add_321, 32'd7, 32'd7);
    check("bne_nt_lit", {31'h0, branch_taken}, 32'h0);
    step("bne_nx",  32'h108, add_321);

    // branch after LW: two stall cycles, resolves on the third
    step("blw_ld", 32'h200, beq_45);
    step("blw_ex", 32'h204, add_321, 32'd3, 32'd3, 1'b1, 1'b1, 5'd4);
    step("blw_mm", 32'h204, add_321, 32'd3, 32'd3, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4);
    check("blw_mm_taken_lit", {31'h0, branch_taken}, 32'h0);
    step("blw_rs", 32'h204, add_321, 32'd3, 32'd3);
    check("blw_addr_lit", branch_addr, 32'h20C);
    check("blw_tk_lit", {31'h0, branch_taken}, 32'h1);

    // branch after ALU op on rt: one stall cycle
    step("balu_ld", 32'h300, beq_45);
    step("balu_ex", 32'h304, add_321, 32'd1, 32'd2, 1'b0, 1'b1, 5'd5);
    step("balu_rs", 32'h304, add_321, 32'd1, 32'd2);

    // J
    step("j_ld", 32'h1000_0004, j_40);
    step("j_tk", 32'h1000_0008, add_321);
    check("j_addr_lit", branch_addr, 32'h1000_0100);

    // $0 never creates a hazard
    step("r0_ld", 32'h400, add_300);
    step("r0_ex", 32'h404, add_321, 0, 0, 1'b1, 1'b1, 5'd0);

    // async reset in the middle of a stall
    step("ar_ld", 32'h20, add_321);
    step("ar_s1", 32'h24, 32'h0, 0, 0, 1'b1, 1'b1, 5'd1);
    step("ar_s2", 32'h24, 32'h0, 0, 0, 1'b1, 1'b1, 5'd1);
    #2 rst = 1'b1;
    #1;
    check("ar.inst",   if_id_inst, 32'h0);
    check("ar.pc",     if_id_pc,   32'h0);
    check("ar.freeze", {31'h0, freeze},    32'h0);
    check("ar.stall",  {16'h0, stall_cnt}, 32'h0);
    check("ar.flush",  {16'h0, flush_cnt}, 32'h0);
    release_reset();

    // hold a load-use hazard long enough to saturate stall_cnt
    step("sat_ld", 32'h40, add_321);
    for (int i = 0; i < 65540; i++)
      step("sat", 32'h44, 32'h0, 0, 0, 1'b1, 1'b0, 5'd2);
    check("sat_lit", {16'h0, stall_cnt}, 32'h0000_FFFF);
    step("sat_end", 32'h44, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
